morgan_sweep_ctrl: RTL and testbench

MORGAN_SWEEP_CTRL -- requirements
Module: morgan_sweep_ctrl

---
 rtl/morgan_pkg.sv | 16 +
 rtl/morgan_cmp3.sv | 13 +
 rtl/morgan_sweep_ctrl.sv | 161 ++++++++++++++++
 tb/tb_morgan_sweep_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/morgan_pkg.sv
// Shared types and sizing for the morgan sweep controller.
package morgan_pkg;

  localparam int unsigned VEC_W    = 6;
  localparam int unsigned NUM_VEC  = 64;
  localparam int unsigned CNT_W    = 7;
  localparam int unsigned SETTLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/morgan_cmp3.sv
// Three-way equality check: mismatch is high unless a, b and c all agree.
module morgan_cmp3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic mismatch
);

  always_comb begin
    mismatch = (a ^ b) | (a ^ c);
  end

endmodule

// File: rtl/morgan_sweep_ctrl.sv
// Exhaustive 6-input sweep controller comparing three block outputs per vector.
// Optional first-failure capture ports are enabled by defining FIRST_FAIL_CAPTURE_EN.
module morgan_sweep_ctrl
  import morgan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [VEC_W-1:0] vec,
  input  logic             z_in,
  input  logic             g_in,
  input  logic             h_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             pass
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_valid
`endif
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [VEC_W-1:0]    VEC_LAST    = VEC_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX     = CNT_W'(NUM_VEC);

  state_e                state_q, state_d;
  logic [VEC_W-1:0]      vec_q, vec_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pass_q, pass_d;
  logic                  mismatch;
  logic                  accept;
  logic                  in_sweep;
  logic                  sample_hit;

  morgan_cmp3 u_cmp3 (
    .a        (z_in),
    .b        (g_in),
    .c        (h_in),
    .mismatch (mismatch)
  );

  always_comb begin
    accept     = (state_q == ST_IDLE) && start && !abort;
    in_sweep   = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    // A mismatch seen in the same cycle as abort is discarded.
    sample_hit = (state_q == ST_SAMPLE) && !abort && mismatch;
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;

    if (in_sweep && abort) begin
      state_d  = ST_IDLE;
      vec_d    = '0;
      settle_d = '0;
      pass_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d  = ST_SETTLE;
            vec_d    = '0;
            cnt_d    = '0;
            pass_d   = 1'b0;
            settle_d = SETTLE_LOAD;
          end
        end
        ST_SETTLE: begin
          settle_d = settle_q - SETTLE_W'(1);
          if (settle_q <= SETTLE_W'(1)) begin
            state_d = ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (sample_hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
          end else begin
            vec_d    = vec_q + VEC_W'(1);
            settle_d = SETTLE_LOAD;
            state_d  = ST_SETTLE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          pass_d  = (cnt_q == '0);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      cnt_q    <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      pass_q   <= pass_d;
    end
  end

`ifdef FIRST_FAIL_CAPTURE_EN
  logic [VEC_W-1:0] ff_vec_q, ff_vec_d;
  logic             ff_valid_q, ff_valid_d;

  always_comb begin
    ff_vec_d   = ff_vec_q;
    ff_valid_d = ff_valid_q;
    if (accept) begin
      ff_vec_d   = '0;
      ff_valid_d = 1'b0;
    end else if (sample_hit && !ff_valid_q) begin
      ff_vec_d   = vec_q;
      ff_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ff_vec_q   <= '0;
      ff_valid_q <= 1'b0;
    end else begin
      ff_vec_q   <= ff_vec_d;
      ff_valid_q <= ff_valid_d;
    end
  end

  always_comb begin
    first_fail_vec   = ff_vec_q;
    first_fail_valid = ff_valid_q;
  end
`endif

  always_comb begin
    vec          = vec_q;
    busy         = in_sweep;
    done         = (state_q == ST_DONE);
    mismatch_cnt = cnt_q;
    pass         = pass_q;
  end

endmodule

// File: tb/tb_morgan_sweep_ctrl.sv
// Self-checking bench for morgan_sweep_ctrl: vector table, random fault masks,
// reset/abort/restart sequences, and a SETTLE_CYCLES=3 latency check.
module tb_morgan_sweep_ctrl;

  localparam int S  = 1;
  localparam int NV = 64;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [5:0]  vec;
  logic        z_in, g_in, h_in;
  logic        busy, done, pass;
  logic [6:0]  mismatch_cnt;
  logic [63:0] mask;

  logic        start3;
  logic [5:0]  vec3;
  logic        z3;
  logic        busy3, done3, pass3;
  logic [6:0]  cnt3;

`ifdef FIRST_FAIL_CAPTURE_EN
  logic [5:0]  ff_vec, ff_vec3;
  logic        ff_valid, ff_valid3;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // External block model: golden function, with h flipped on masked vectors.
  assign z_in = ~&vec;
  assign g_in = ~&vec;
  assign h_in = (~&vec) ^ mask[vec];
  assign z3   = ~&vec3;

  morgan_sweep_ctrl #(.SETTLE_CYCLES(S)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .vec          (vec),
    .z_in         (z_in),
    .g_in         (g_in),
    .h_in         (h_in),
    .busy         (busy),
    .done         (done),
    .mismatch_cnt (mismatch_cnt),
    .pass         (pass)
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    .first_fail_vec   (ff_vec),
    .first_fail_valid (ff_valid)
`endif
  );

  morgan_sweep_ctrl #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk          (clk),
    .rst          (rst),
    .start        (start3),
    .abort        (1'b0),
    .vec          (vec3),
    .z_in         (z3),
    .g_in         (z3),
    .h_in         (z3),
    .busy         (busy3),
    .done         (done3),
    .mismatch_cnt (cnt3),
    .pass         (pass3)
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    .first_fail_vec   (ff_vec3),
    .first_fail_valid (ff_valid3)
`endif
  );

  typedef struct {
    logic [63:0] mask;
    int          abort_vec;
    int          restart_vec;
    int          exp_cnt;
    int          exp_pass;
    int          exp_dones;
    int          exp_ff;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int popc(input logic [63:0] m, input int n);
    int r = 0;
    for (int i = 0; i < n && i < NV; i++) r += int'(m[i]);
    return r;
  endfunction

  function automatic int first_set(input logic [63:0] m, input int n);
    for (int i = 0; i < n && i < NV; i++) if (m[i]) return i;
    return -1;
  endfunction

  // One sweep; checks vec/busy/done/count/pass every cycle against the timing model
  // where vector k is presented for S+1 cycles starting k*(S+1) cycles after accept.
  task automatic run_sweep(input logic [63:0] m, input int abort_vec, input int restart_vec,
                           output int cnt_o, output int pass_o, output int dones);
    int limit, ab_c, rs_c;
    int bad_vec, bad_busy, bad_done, bad_cnt, bad_pass;
    int e_vec, e_busy, e_done, e_cnt, e_pass;
    bit aborted;
    limit    = NV * (S + 1);
    ab_c     = (abort_vec >= 0) ? abort_vec * (S + 1) + S : -1;
    rs_c     = (restart_vec >= 0) ? restart_vec * (S + 1) : -1;
    bad_vec  = 0; bad_busy = 0; bad_done = 0; bad_cnt = 0; bad_pass = 0;
    dones    = 0;
    mask     = m;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c <= limit + 3; c++) begin
      aborted = (ab_c >= 0) && (c > ab_c);
      if (aborted) begin
        e_vec = 0; e_busy = 0; e_done = 0;
        e_cnt = popc(m, abort_vec); e_pass = 0;
      end else if (c < limit) begin
        e_vec = c / (S + 1); e_busy = 1; e_done = 0;
        e_cnt = popc(m, c / (S + 1)); e_pass = 0;
      end else begin
        e_vec = 63; e_busy = 0; e_done = (c == limit) ? 1 : 0;
        e_cnt = popc(m, NV);
        e_pass = (c > limit && e_cnt == 0) ? 1 : 0;
      end
      if (int'(vec) != e_vec) bad_vec++;
      if (int'(busy) != e_busy) bad_busy++;
      if (int'(done) != e_done) bad_done++;
      if (int'(mismatch_cnt) != e_cnt) bad_cnt++;
      if (int'(pass) != e_pass) bad_pass++;
      dones += int'(done);
      abort = (c == ab_c);
      start = (c == rs_c);
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
    chk("vec_trace_bad_cycles", bad_vec, 0);
    chk("busy_trace_bad_cycles", bad_busy, 0);
    chk("done_trace_bad_cycles", bad_done, 0);
    chk("cnt_trace_bad_cycles", bad_cnt, 0);
    chk("pass_trace_bad_cycles", bad_pass, 0);
    cnt_o  = int'(mismatch_cnt);
    pass_o = int'(pass);
  endtask

  initial begin
    int cnt_o, pass_o, dones, av, e_cnt, bound, waited, done_at, bad_hold;
    logic [63:0] m;

    tbl[0] = '{64'h0,                             -1, -1,  0, 1, 1, -1};
    tbl[1] = '{64'h8000_0400_0000_0000,           -1, -1,  2, 0, 1, 42};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF,           -1, -1, 64, 0, 1,  0};
    tbl[3] = '{64'h0000_0000_0000_0001,           -1, -1,  1, 0, 1,  0};
    tbl[4] = '{64'h0000_0000_4010_0020,           20, -1,  1, 0, 0,  5};
    tbl[5] = '{64'h0,                             -1,  5,  0, 1, 1, -1};
    tbl[6] = '{64'h8000_0000_0000_0001,            0, -1,  0, 0, 0, -1};

    rst = 1'b1; start = 1'b1; abort = 1'b1; start3 = 1'b0; mask = '0;
    repeat (3) @(negedge clk);
    start = 1'b0; abort = 1'b0;
    rst = 1'b0;
    chk("reset_vec", int'(vec), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_cnt", int'(mismatch_cnt), 0);
    chk("reset_pass", int'(pass), 0);
`ifdef FIRST_FAIL_CAPTURE_EN
    chk("reset_ff_valid", int'(ff_valid), 0);
    chk("reset_ff_vec", int'(ff_vec), 0);
`endif

    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle_busy", int'(busy), 0);

    for (int i = 0; i < 7; i++) begin
      run_sweep(tbl[i].mask, tbl[i].abort_vec, tbl[i].restart_vec, cnt_o, pass_o, dones);
      chk($sformatf("tbl%0d_cnt", i), cnt_o, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_pass", i), pass_o, tbl[i].exp_pass);
      chk($sformatf("tbl%0d_dones", i), dones, tbl[i].exp_dones);
`ifdef FIRST_FAIL_CAPTURE_EN
      chk($sformatf("tbl%0d_ff_valid", i), int'(ff_valid), (tbl[i].exp_ff >= 0) ? 1 : 0);
      if (tbl[i].exp_ff >= 0) chk($sformatf("tbl%0d_ff_vec", i), int'(ff_vec), tbl[i].exp_ff);
`endif
    end

    for (int r = 0; r < 6; r++) begin
      m  = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      av = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 62)) : -1;
      bound = (av >= 0) ? av : NV;
      e_cnt = popc(m, bound);
      run_sweep(m, av, -1, cnt_o, pass_o, dones);
      chk($sformatf("rand%0d_cnt", r), cnt_o, e_cnt);
      chk($sformatf("rand%0d_pass", r), pass_o, (av < 0 && e_cnt == 0) ? 1 : 0);
      chk($sformatf("rand%0d_dones", r), dones, (av < 0) ? 1 : 0);
`ifdef FIRST_FAIL_CAPTURE_EN
      chk($sformatf("rand%0d_ff_valid", r), int'(ff_valid), (first_set(m, bound) >= 0) ? 1 : 0);
      if (first_set(m, bound) >= 0) chk($sformatf("rand%0d_ff_vec", r), int'(ff_vec), first_set(m, bound));
`endif
    end

    // Reset in the middle of a sweep with a non-zero partial count.
    mask = 64'h0000_0000_4000_0400;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    waited = 0;
    while (vec != 6'd40 && waited < 200) begin
      @(negedge clk); waited++;
    end
    chk("rst_wait_vec40_timeout", (waited < 200) ? 1 : 0, 1);
    chk("rst_precount", int'(mismatch_cnt), 2);
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    chk("midrst_vec", int'(vec), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_cnt", int'(mismatch_cnt), 0);
    chk("midrst_pass", int'(pass), 0);
    run_sweep(64'h0, -1, -1, cnt_o, pass_o, dones);
    chk("post_rst_pass", pass_o, 1);
    chk("post_rst_dones", dones, 1);

    // Longer settle time: each vector held 4 cycles, done 256 cycles after accept.
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    done_at = -1; bad_hold = 0;
    for (int c = 0; c < 270; c++) begin
      if (c < 256 && int'(vec3) != c / 4) bad_hold++;
      if (done3 && done_at < 0) done_at = c;
      @(negedge clk);
    end
    chk("s3_vec_hold_bad_cycles", bad_hold, 0);
    chk("s3_done_cycle", done_at, 256);
    chk("s3_pass", int'(pass3), 1);
    chk("s3_cnt", int'(cnt3), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout actual=expired required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
